// File: rtl/riscv_ras_stack.sv
// Return-address stack: circular LIFO of predicted return addresses with
// top-of-stack and fill-count outputs for the fetch redirect and RAS control.
module riscv_ras_stack #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned RAS_DEPTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_pop_then_push,
  input  logic [ADDR_WIDTH-1:0] i_ret_addr,
  output logic [ADDR_WIDTH-1:0] o_top_addr,
  output logic                  o_top_valid,
  output logic [ADDR_WIDTH-1:0] o_ras_addr,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_FLUSH,
    OP_PTP,
    OP_PUSH,
    OP_POP
  } op_e;

  logic [ADDR_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]      tp;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf_q;
  logic                  unf_q;

  op_e                   op;
  logic [PTR_W-1:0]      tp_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  ovf_nxt;
  logic                  unf_nxt;
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_idx;
  logic                  empty;
  logic                  full;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_FULL);

  // Resolve simultaneous commands by fixed priority: flush > pop_then_push > push > pop.
  always_comb begin
    op = OP_NONE;
    if (i_flush)              op = OP_FLUSH;
    else if (i_pop_then_push) op = OP_PTP;
    else if (i_push)          op = OP_PUSH;
    else if (i_pop)           op = OP_POP;
  end

  // Next pointer/count, array write strobe and error pulses for the chosen command.
  always_comb begin
    tp_nxt  = tp;
    cnt_nxt = cnt;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = tp;
    unique case (op)
      OP_FLUSH: begin
        tp_nxt  = '0;
        cnt_nxt = '0;
      end
      OP_PTP: begin
        if (empty) begin
          // Replacing a non-existent top degenerates into a plain push.
          tp_nxt  = tp + 1'b1;
          wr_idx  = tp + 1'b1;
          cnt_nxt = CNT_W'(1);
          unf_nxt = 1'b1;
        end else begin
          wr_idx = tp;
        end
        wr_en = 1'b1;
      end
      OP_PUSH: begin
        tp_nxt = tp + 1'b1;
        wr_idx = tp + 1'b1;
        wr_en  = 1'b1;
        if (full) ovf_nxt = 1'b1;
        else      cnt_nxt = cnt + 1'b1;
      end
      OP_POP: begin
        if (empty) begin
          unf_nxt = 1'b1;
        end else begin
          tp_nxt  = tp - 1'b1;
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pointer, count and pulse registers; reset discards any same-cycle command.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tp    <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tp    <= tp_nxt;
      cnt   <= cnt_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
    end
  end

  // Address array: never read while empty, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_rst) mem[wr_idx] <= i_ret_addr;
  end

  assign o_top_valid = !empty;
  assign o_top_addr  = empty ? '0 : mem[tp];
  assign o_ras_addr  = ADDR_WIDTH'(cnt);
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_riscv_ras_stack.sv
// Bench for riscv_ras_stack: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_riscv_ras_stack;

  localparam int unsigned AW = 64;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, flush, push, pop, ptp;
  logic [AW-1:0] ret_addr;
  logic [AW-1:0] top_addr, ras_cnt;
  logic          top_valid, ovf, unf;

  int checks = 0;
  int failures = 0;

  riscv_ras_stack #(.ADDR_WIDTH(AW), .RAS_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_push(push), .i_pop(pop),
    .i_pop_then_push(ptp), .i_ret_addr(ret_addr),
    .o_top_addr(top_addr), .o_top_valid(top_valid), .o_ras_addr(ras_cnt),
    .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  // Reference model: newest entry at the back of the queue.
  logic [AW-1:0] q[$];
  logic          m_ovf = 1'b0, m_unf = 1'b0, live = 1'b0;

  always @(posedge clk) begin
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (rst) begin
      q.delete();
      live = 1'b1;
    end else if (flush) begin
      q.delete();
    end else if (ptp) begin
      if (q.size() == 0) begin
        q.push_back(ret_addr);
        m_unf = 1'b1;
      end else begin
        q[q.size()-1] = ret_addr;
      end
    end else if (push) begin
      q.push_back(ret_addr);
      if (q.size() > DEPTH) begin
        void'(q.pop_front());
        m_ovf = 1'b1;
      end
    end else if (pop) begin
      if (q.size() == 0) m_unf = 1'b1;
      else void'(q.pop_back());
    end
  end

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      check("m_top",   top_addr, (q.size() != 0) ? q[q.size()-1] : '0);
      check("m_valid", AW'(top_valid), AW'(q.size() != 0));
      check("m_count", ras_cnt, AW'(q.size()));
      check("m_ovf",   AW'(ovf), AW'(m_ovf));
      check("m_unf",   AW'(unf), AW'(m_unf));
    end
  end

  // Drive one command for one rising edge; returns at the following negedge.
  task automatic cmd(input logic r, input logic f, input logic pu, input logic po,
                     input logic pp, input logic [AW-1:0] a);
    rst = r; flush = f; push = pu; pop = po; ptp = pp; ret_addr = a;
    @(negedge clk);
    rst = 0; flush = 0; push = 0; pop = 0; ptp = 0; ret_addr = '0;
  endtask

  task automatic do_push(input logic [AW-1:0] a); cmd(0, 0, 1, 0, 0, a); endtask
  task automatic do_pop();                        cmd(0, 0, 0, 1, 0, '0); endtask
  task automatic do_idle();                       cmd(0, 0, 0, 0, 0, '0); endtask

  initial begin
    rst = 0; flush = 0; push = 0; pop = 0; ptp = 0; ret_addr = '0;
    @(negedge clk);
    cmd(1, 0, 0, 0, 0, '0);
    cmd(1, 0, 0, 0, 0, '0);
    check("rst_count", ras_cnt, 64'd0);
    check("rst_valid", AW'(top_valid), 64'd0);
    check("rst_top", top_addr, 64'd0);

    // Basic push/pop
    do_push(64'h1000);
    do_push(64'h2000);
    check("pp_top2", top_addr, 64'h2000);
    check("pp_cnt2", ras_cnt, 64'd2);
    do_pop();
    check("pp_top1", top_addr, 64'h1000);
    check("pp_cnt1", ras_cnt, 64'd1);
    do_pop();
    check("pp_valid0", AW'(top_valid), 64'd0);
    check("pp_top0", top_addr, 64'd0);

    // Underflow on empty pop
    do_pop();
    check("unf_pulse", AW'(unf), 64'd1);
    check("unf_cnt", ras_cnt, 64'd0);
    do_idle();
    check("unf_clear", AW'(unf), 64'd0);

    // Overflow wrap with 17 pushes
    for (int i = 0; i < 17; i++) begin
      do_push(64'h100 + 64'(4 * i));
      if (i == 15) check("full_no_ovf", AW'(ovf), 64'd0);
    end
    check("ovf_pulse", AW'(ovf), 64'd1);
    check("ovf_cnt", ras_cnt, 64'd16);
    check("ovf_top", top_addr, 64'h140);
    do_idle();
    check("ovf_clear", AW'(ovf), 64'd0);
    for (int k = 1; k <= 16; k++) begin
      do_pop();
      if (k < 16) check("wrap_pop_top", top_addr, 64'h140 - 64'(4 * k));
    end
    check("wrap_empty", AW'(top_valid), 64'd0);

    // pop_then_push replaces the top only
    do_push(64'h100);
    do_push(64'h200);
    do_push(64'h300);
    cmd(0, 0, 0, 0, 1, 64'h500);
    check("ptp_top", top_addr, 64'h500);
    check("ptp_cnt", ras_cnt, 64'd3);
    do_pop();
    check("ptp_next", top_addr, 64'h200);

    // push beats pop; flush beats push
    cmd(0, 0, 1, 1, 0, 64'h700);
    check("pushpop_cnt", ras_cnt, 64'd3);
    check("pushpop_top", top_addr, 64'h700);
    cmd(0, 1, 1, 0, 0, 64'h800);
    check("flush_cnt", ras_cnt, 64'd0);
    check("flush_valid", AW'(top_valid), 64'd0);

    // pop_then_push on empty acts as push and flags underflow
    cmd(0, 0, 0, 0, 1, 64'hABC);
    check("ptp_e_unf", AW'(unf), 64'd1);
    check("ptp_e_cnt", ras_cnt, 64'd1);
    check("ptp_e_top", top_addr, 64'hABC);
    cmd(0, 0, 0, 0, 1, 64'hDEF);
    check("ptp_e_unf_clr", AW'(unf), 64'd0);
    check("ptp_e_repl", top_addr, 64'hDEF);

    // Reset with a pending push
    do_push(64'h11);
    do_push(64'h22);
    do_push(64'h33);
    do_push(64'h44);
    check("pre_rst_cnt", ras_cnt, 64'd5);
    cmd(1, 0, 1, 0, 0, 64'h55);
    check("rst_mid_cnt", ras_cnt, 64'd0);
    check("rst_mid_top", top_addr, 64'd0);
    check("rst_mid_valid", AW'(top_valid), 64'd0);
    check("rst_mid_ovf", AW'(ovf), 64'd0);
    check("rst_mid_unf", AW'(unf), 64'd0);
    do_push(64'h66);
    check("post_rst_top", top_addr, 64'h66);
    check("post_rst_cnt", ras_cnt, 64'd1);

    do_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_ras_stack.md
# riscv_ras_stack

Return-address stack storage for the RISC-V front end. It consumes the push, pop and pop-then-push commands produced by the RAS control logic in EX. It keeps a circular LIFO of predicted return addresses and presents the top-of-stack address and a fill count. Fetch uses the top address to redirect returns; the control logic uses the count to qualify its commands.

## Interface
- ADDR_WIDTH, 64, width of a return address and of o_ras_addr
- RAS_DEPTH, 16, number of entries; power of two, ≥ 2
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_flush  input  1  pipeline flush: empties the stack
- i_push  input  1  push i_ret_addr
- i_pop  input  1  discard top entry
- i_pop_then_push  input  1  replace top entry with i_ret_addr
- i_ret_addr  input  ADDR_WIDTH  return address (link PC) to store
- o_top_addr  output  ADDR_WIDTH  current top entry; 0 when empty
- o_top_valid  output  1  stack non-empty
- o_ras_addr  output  ADDR_WIDTH  fill count, zero-extended (0..RAS_DEPTH)
- o_overflow  output  1  one-cycle pulse: push overwrote oldest entry
- o_underflow  output  1  one-cycle pulse: pop or pop-then-push on empty stack

## Operation
- Storage: RAS_DEPTH × ADDR_WIDTH register array; top pointer tp of $clog2(RAS_DEPTH) bits; count cnt of $clog2(RAS_DEPTH)+1 bits.
- Command priority per cycle: i_rst > i_flush > i_pop_then_push > i_push > i_pop. Lower-priority commands in the same cycle are ignored.
- push:
  - tp ← tp+1 (mod RAS_DEPTH); mem[tp+1] ← i_ret_addr.
  - If cnt < RAS_DEPTH: cnt ← cnt+1.
  - Else (full): cnt holds at RAS_DEPTH, the oldest entry is overwritten (wrap-around), o_overflow pulses.
- pop:
  - If cnt > 0: tp ← tp−1 (mod RAS_DEPTH), cnt ← cnt−1.
  - If cnt = 0: no state change; o_underflow pulses.
- pop_then_push:
  - If cnt > 0: mem[tp] ← i_ret_addr; tp and cnt unchanged.
  - If cnt = 0: behaves as a push of i_ret_addr (cnt ← 1); o_underflow pulses.
- flush: tp ← 0, cnt ← 0. Array contents are not cleared.
- Outputs:
  - o_top_addr = (cnt ≠ 0) ? mem[tp] : 0.
  - o_top_valid = (cnt ≠ 0).
  - o_ras_addr = {zeros, cnt}.
- Array contents are never read when cnt = 0, so the array needs no reset.

## Timing
- Reset (i_rst high at a rising edge): tp = 0, cnt = 0, o_top_addr = 0, o_top_valid = 0, o_ras_addr = 0, o_overflow = 0, o_underflow = 0.
- Reset mid-operation discards any command in the same cycle.
- Commands are sampled at the rising edge. o_top_addr, o_top_valid and o_ras_addr reflect the command from the cycle after that edge (1-cycle latency). They are combinational from registered state only; there is no input-to-output combinational path.
- o_overflow and o_underflow are registered and high for exactly the cycle following the offending command.
- Back-to-back commands are accepted every cycle with no stall and no ready handshake.
- Full and then pop: the pop is accepted and cnt goes RAS_DEPTH → RAS_DEPTH−1. After an overflow, RAS_DEPTH consecutive pops are valid and return the newest RAS_DEPTH addresses in LIFO order.

## Test plan
- Reset and push A=0x1000, then push B=0x2000 → o_top_addr = 0x2000, o_ras_addr = 2. Pop → o_top_addr = 0x1000, count 1. Pop → o_top_valid = 0, o_top_addr = 0, count 0.
- Pop on empty → o_underflow high for 1 cycle; count stays 0, o_top_valid stays 0.
- Push 17 addresses 0x100, 0x104, … 0x140 (RAS_DEPTH = 16):
  - The 17th push raises o_overflow for 1 cycle; count stays 16.
  - 16 pops return 0x140 down to 0x104; then o_top_valid = 0.
- With count 3 and top 0x300, pop_then_push 0x500 → top = 0x500, count 3. The next pop exposes the previous second entry.
- Assert push and pop together with 0x700 → push wins, count +1. Assert flush together with push → count 0, o_top_valid = 0.
- Raise i_rst while count = 5 and a push is pending → next cycle all outputs are 0 and the push is lost.
